// File: rtl/split_reg.sv
// Registered 1-to-N address splitter for the native valid/ready bus.
// One outstanding transaction; decode misses and slave timeouts return an error response.
module split_reg #(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int P_SLAVES = ADDR_W - 1,
  parameter int SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  parameter int TIMEOUT  = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           m_valid,
  input  logic [ADDR_W-1:0]              m_addr,
  input  logic [DATA_W-1:0]              m_wdata,
  input  logic [DATA_W/8-1:0]            m_wstrb,
  output logic [DATA_W-1:0]              m_rdata,
  output logic                           m_ready,
  output logic                           m_err,
  output logic [N_SLAVES-1:0]            s_valid,
  output logic [N_SLAVES*ADDR_W-1:0]     s_addr,
  output logic [N_SLAVES*DATA_W-1:0]     s_wdata,
  output logic [N_SLAVES*DATA_W/8-1:0]   s_wstrb,
  input  logic [N_SLAVES*DATA_W-1:0]     s_rdata,
  input  logic [N_SLAVES-1:0]            s_ready,
  output logic [15:0]                    err_cnt
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SEL_W-1:0]   r_sel;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_err_cnt;

  logic [SEL_W-1:0]   w_sel;
  logic               w_hit;
  logic               w_rdy;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_tmo;

  assign w_sel   = m_addr[P_SLAVES -: SEL_W];
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign err_cnt = r_err_cnt;

  // Hit/mux by enumeration so field values beyond N_SLAVES never index past the port vectors.
  always_comb begin
    w_hit   = 1'b0;
    w_rdy   = 1'b0;
    w_rdata = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (w_sel == SEL_W'(i)) w_hit = 1'b1;
      if (r_sel == SEL_W'(i)) begin
        w_rdy   = s_ready[i];
        w_rdata = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && m_valid) begin
        r_sel <= w_sel;
        r_cnt <= '0;
      end else if (r_state == S_BUSY && !w_rdy && TIMEOUT != 0) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == S_ERR && r_err_cnt != 16'hFFFF) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (m_valid) w_next = w_hit ? S_BUSY : S_ERR;
      S_BUSY: begin
        if (w_rdy)      w_next = S_IDLE;
        else if (w_tmo) w_next = S_ERR;
      end
      S_ERR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_valid = '0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_rdata = '0;
    case (r_state)
      S_BUSY: begin
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
          if (r_sel == SEL_W'(i)) begin
            s_valid[i]                   = m_valid;
            s_addr[i*ADDR_W +: ADDR_W]   = m_addr;
            s_wdata[i*DATA_W +: DATA_W]  = m_wdata;
            s_wstrb[i*STRB_W +: STRB_W]  = m_wstrb;
          end
        end
        m_ready = w_rdy;
        m_rdata = w_rdy ? w_rdata : '0;
      end
      S_ERR: begin
        m_ready = 1'b1;
        m_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
